// File: rtl/hack_cpu_ctrl.sv
// Hack CPU control and datapath registers: fetches over valid/ready, decodes C-instructions
// for the neighbouring combinational ALU, writes back A/D/M and resolves jumps from zr/ng.
module hack_cpu_ctrl #(
   parameter int unsigned          ADDR_W   = 15,
   parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       instr,
   input  logic              instr_valid,
   output logic              instr_ready,
   output logic [ADDR_W-1:0] pc,
   input  logic [15:0]       inM,
   output logic [15:0]       outM,
   output logic              writeM,
   output logic [ADDR_W-1:0] addressM,
   output logic [15:0]       alu_x,
   output logic [15:0]       alu_y,
   output logic              zx,
   output logic              nx,
   output logic              zy,
   output logic              ny,
   output logic              f,
   output logic              no,
   input  logic [15:0]       alu_o,
   input  logic              alu_zr,
   input  logic              alu_ng
);

   typedef enum logic [0:0] {StFetch, StExec} state_e;

   state_e            state_q, state_d;
   logic [15:0]       a_q, a_d;
   logic [15:0]       d_q, d_d;
   logic [15:0]       ir_q, ir_d;
   logic [ADDR_W-1:0] pc_q, pc_d;

   logic              exec_c;
   logic              jump;
   logic [ADDR_W-1:0] pc_inc;

   assign exec_c = (state_q == StExec) && ir_q[15];
   assign pc_inc = pc_q + ADDR_W'(1);
   assign jump   = (ir_q[2] & alu_ng) | (ir_q[1] & alu_zr) | (ir_q[0] & ~alu_ng & ~alu_zr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFetch;
         a_q     <= '0;
         d_q     <= '0;
         ir_q    <= '0;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         d_q     <= d_d;
         ir_q    <= ir_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      d_d     = d_q;
      ir_d    = ir_q;
      pc_d    = pc_q;
      unique case (state_q)
         StFetch: begin
            if (instr_valid) begin
               ir_d    = instr;
               state_d = StExec;
            end
         end
         StExec: begin
            state_d = StFetch;
            if (!ir_q[15]) begin
               a_d  = ir_q;
               pc_d = pc_inc;
            end else begin
               if (ir_q[5]) a_d = alu_o;
               if (ir_q[4]) d_d = alu_o;
               // Jump target is the A value from before this instruction's writeback.
               pc_d = jump ? a_q[ADDR_W-1:0] : pc_inc;
            end
         end
         default: state_d = StFetch;
      endcase
   end

   always_comb begin
      instr_ready = (state_q == StFetch);
      pc          = pc_q;
      alu_x       = d_q;
      alu_y       = a_q;
      outM        = alu_o;
      addressM    = a_q[ADDR_W-1:0];
      writeM      = 1'b0;
      {zx, nx, zy, ny, f, no} = 6'b0;
      if (exec_c) begin
         {zx, nx, zy, ny, f, no} = ir_q[11:6];
         if (ir_q[12]) alu_y = inM;
         writeM = ir_q[3];
      end
   end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed bench for hack_cpu_ctrl: a behavioural Hack ALU closes the loop around two instances
// (default reset PC and RESET_PC at the top of the address space).
module tb_hack_cpu_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance 1: default parameters
   logic        rst_n = 1'b1;
   logic [15:0] instr = '0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [14:0] pc, addressM;
   logic [15:0] inM = '0;
   logic [15:0] outM, alu_x, alu_y, alu_o;
   logic        writeM, zx, nx, zy, ny, f, no, alu_zr, alu_ng;

   // Instance 2: RESET_PC = 0x7FFF
   logic        rst_n2 = 1'b1;
   logic [15:0] instr2 = '0;
   logic        instr_valid2 = 1'b0;
   logic        instr_ready2;
   logic [14:0] pc2, addressM2;
   logic [15:0] outM2, alu_x2, alu_y2, alu_o2;
   logic        writeM2, zx2, nx2, zy2, ny2, f2, no2, alu_zr2, alu_ng2;

   hack_cpu_ctrl dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .pc(pc), .inM(inM), .outM(outM), .writeM(writeM),
      .addressM(addressM), .alu_x(alu_x), .alu_y(alu_y), .zx(zx), .nx(nx), .zy(zy),
      .ny(ny), .f(f), .no(no), .alu_o(alu_o), .alu_zr(alu_zr), .alu_ng(alu_ng)
   );

   hack_cpu_ctrl #(.ADDR_W(15), .RESET_PC(15'h7FFF)) dut2 (
      .clk(clk), .rst_n(rst_n2), .instr(instr2), .instr_valid(instr_valid2),
      .instr_ready(instr_ready2), .pc(pc2), .inM(16'h0000), .outM(outM2), .writeM(writeM2),
      .addressM(addressM2), .alu_x(alu_x2), .alu_y(alu_y2), .zx(zx2), .nx(nx2), .zy(zy2),
      .ny(ny2), .f(f2), .no(no2), .alu_o(alu_o2), .alu_zr(alu_zr2), .alu_ng(alu_ng2)
   );

   function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                            input logic [5:0] c);
      logic [15:0] xx, yy, o;
      xx = c[5] ? 16'h0 : x;
      xx = c[4] ? ~xx : xx;
      yy = c[3] ? 16'h0 : y;
      yy = c[2] ? ~yy : yy;
      o  = c[1] ? xx + yy : xx & yy;
      o  = c[0] ? ~o : o;
      return o;
   endfunction

   assign alu_o   = hack_alu(alu_x, alu_y, {zx, nx, zy, ny, f, no});
   assign alu_zr  = (alu_o == 16'h0);
   assign alu_ng  = alu_o[15];
   assign alu_o2  = hack_alu(alu_x2, alu_y2, {zx2, nx2, zy2, ny2, f2, no2});
   assign alu_zr2 = (alu_o2 == 16'h0);
   assign alu_ng2 = alu_o2[15];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present ins in FETCH, take the accept edge; returns #1 into EXEC.
   task automatic issue(input logic [15:0] ins);
      instr       = ins;
      instr_valid = 1'b1;
      chk("fetch_ready", {31'b0, instr_ready}, 32'd1);
      @(posedge clk); #1;
      instr_valid = 1'b0;
      chk("exec_ready", {31'b0, instr_ready}, 32'd0);
   endtask

   task automatic retire();
      @(posedge clk); #1;
   endtask

   task automatic issue2(input logic [15:0] ins);
      instr2       = ins;
      instr_valid2 = 1'b1;
      @(posedge clk); #1;
      instr_valid2 = 1'b0;
   endtask

   initial begin
      #2 rst_n = 1'b0; rst_n2 = 1'b0;
      #10;
      chk("rst_ready", {31'b0, instr_ready}, 32'd1);
      chk("rst_pc", {17'b0, pc}, 32'h0);
      chk("rst_writeM", {31'b0, writeM}, 32'd0);
      chk("rst_D", {16'b0, alu_x}, 32'h0);
      chk("rst_A", {16'b0, alu_y}, 32'h0);
      chk("rst_ctrl", {26'b0, zx, nx, zy, ny, f, no}, 32'h0);
      chk("rst2_pc", {17'b0, pc2}, 32'h7FFF);
      @(negedge clk); rst_n = 1'b1; rst_n2 = 1'b1;
      @(posedge clk); #1;

      // @12
      issue(16'h000C);
      chk("a_ctrl", {26'b0, zx, nx, zy, ny, f, no}, 32'h0);
      chk("a_writeM", {31'b0, writeM}, 32'd0);
      retire();
      chk("a_pc", {17'b0, pc}, 32'd1);
      chk("a_A", {16'b0, alu_y}, 32'd12);

      // D=A
      issue(16'hEC10);
      chk("dA_ctrl", {26'b0, zx, nx, zy, ny, f, no}, 32'b110000);
      retire();
      chk("dA_D", {16'b0, alu_x}, 32'd12);
      chk("dA_A", {16'b0, alu_y}, 32'd12);
      chk("dA_pc", {17'b0, pc}, 32'd2);

      // D=D+A
      issue(16'hE090);
      chk("add_ctrl", {26'b0, zx, nx, zy, ny, f, no}, 32'b000010);
      retire();
      chk("add_D", {16'b0, alu_x}, 32'd24);

      // M=D
      issue(16'hE308);
      chk("st_writeM", {31'b0, writeM}, 32'd1);
      chk("st_addr", {17'b0, addressM}, 32'd12);
      chk("st_outM", {16'b0, outM}, 32'd24);
      retire();
      chk("st_writeM_off", {31'b0, writeM}, 32'd0);
      chk("st_D", {16'b0, alu_x}, 32'd24);
      chk("st_pc", {17'b0, pc}, 32'd4);

      // @100; D;JLT (no jump); D;JGT (jump)
      issue(16'h0064);
      retire();
      chk("a100_pc", {17'b0, pc}, 32'd5);
      issue(16'hE304);
      chk("jlt_writeM", {31'b0, writeM}, 32'd0);
      retire();
      chk("jlt_pc", {17'b0, pc}, 32'd6);
      issue(16'hE301);
      retire();
      chk("jgt_pc", {17'b0, pc}, 32'd100);

      // 0;JMP
      issue(16'hEA87);
      chk("jmp_ctrl", {26'b0, zx, nx, zy, ny, f, no}, 32'b101010);
      chk("jmp_zr", {31'b0, alu_zr}, 32'd1);
      retire();
      chk("jmp_pc", {17'b0, pc}, 32'd100);
      chk("jmp_D", {16'b0, alu_x}, 32'd24);

      // @12; D=M with inM=BEEF
      issue(16'h000C);
      retire();
      inM = 16'hBEEF;
      issue(16'hFC10);
      chk("dm_alu_y", {16'b0, alu_y}, 32'hBEEF);
      retire();
      chk("dm_D", {16'b0, alu_x}, 32'hBEEF);
      chk("dm_A", {16'b0, alu_y}, 32'd12);
      chk("dm_pc", {17'b0, pc}, 32'd102);

      // Stall in FETCH
      instr = 16'h0055;
      repeat (5) @(posedge clk);
      #1;
      chk("stall_ready", {31'b0, instr_ready}, 32'd1);
      chk("stall_pc", {17'b0, pc}, 32'd102);
      chk("stall_A", {16'b0, alu_y}, 32'd12);
      chk("stall_D", {16'b0, alu_x}, 32'hBEEF);

      // instr_valid during EXEC is ignored
      issue(16'h0007);
      instr       = 16'h0009;
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
      chk("ign_A", {16'b0, alu_y}, 32'd7);
      chk("ign_ready", {31'b0, instr_ready}, 32'd1);
      chk("ign_pc", {17'b0, pc}, 32'd103);

      // Instance 2: PC wrap, then reset mid-EXEC of M=D
      issue2(16'h0005);
      @(posedge clk); #1;
      chk("wrap_pc", {17'b0, pc2}, 32'h0000);
      chk("wrap_A", {16'b0, alu_y2}, 32'd5);
      issue2(16'hEC10);
      @(posedge clk); #1;
      chk("w2_D", {16'b0, alu_x2}, 32'd5);
      issue2(16'hE308);
      chk("w2_writeM", {31'b0, writeM2}, 32'd1);
      rst_n2 = 1'b0;
      #1;
      chk("abort_writeM", {31'b0, writeM2}, 32'd0);
      chk("abort_ready", {31'b0, instr_ready2}, 32'd1);
      chk("abort_pc", {17'b0, pc2}, 32'h7FFF);
      chk("abort_A", {16'b0, alu_y2}, 32'h0);
      chk("abort_D", {16'b0, alu_x2}, 32'h0);
      @(negedge clk); rst_n2 = 1'b1;
      @(posedge clk); #1;
      chk("post_pc", {17'b0, pc2}, 32'h7FFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hack_cpu_ctrl.md
Name: hack_cpu_ctrl

Overview:
- Control and datapath-register block that drives the team's 16-bit Hack ALU and consumes its results.
- Fetches Hack instructions over a valid/ready handshake and decodes C-instruction comp bits into the six ALU control bits (zx,nx,zy,ny,f,no).
- Selects the ALU x/y operands, writes the ALU result back to A, D and/or memory, and evaluates jumps from the ALU zr/ng flags to update the PC.
- The ALU itself is instantiated beside this block, in the same parent, and is purely combinational.

Parameters:
- ADDR_W, 15, width of A-derived memory address and PC.
- RESET_PC, 0, PC value loaded on reset; must fit in ADDR_W bits.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- instr  input  16  instruction word from instruction memory.
- instr_valid  input  1  instr is valid this cycle.
- instr_ready  output  1  block accepts instr this cycle.
- pc  output  ADDR_W  address of next instruction to fetch.
- inM  input  16  memory read data at addressM (combinational memory).
- outM  output  16  memory write data.
- writeM  output  1  memory write strobe.
- addressM  output  ADDR_W  memory address = A[ADDR_W-1:0].
- alu_x  output  16  ALU x operand.
- alu_y  output  16  ALU y operand.
- zx, nx, zy, ny, f, no  output  1 each  ALU control bits.
- alu_o  input  16  ALU result.
- alu_zr  input  1  ALU zero flag.
- alu_ng  input  1  ALU negative flag.

Behaviour:
- Registers: A[15:0], D[15:0], IR[15:0], pc[ADDR_W-1:0], state ∈ {FETCH, EXEC}.
- Reset (async, immediate): state=FETCH, A=0, D=0, IR=0, pc=RESET_PC. All outputs combinational from state: instr_ready=1, writeM=0, ALU controls=0. Reset mid-EXEC aborts the instruction with no writeback and no memory write.
- FETCH: instr_ready=1. On instr_valid, IR<=instr and state<=EXEC; otherwise hold. writeM=0. ALU controls=0.
- EXEC: instr_ready=0. Lasts exactly one cycle, then state<=FETCH. Each instruction therefore costs 2 cycles plus any stall waiting for instr_valid.
- A-instruction (IR[15]=0):
  - EXEC edge: A<=IR, pc<=pc+1.
  - writeM=0. ALU controls=0.
- C-instruction (IR[15]=1; IR[14:13] ignored):
  - Combinational during EXEC: {zx,nx,zy,ny,f,no}=IR[11:6]; alu_x=D; alu_y = IR[12] ? inM : A.
  - Destination bits: d1=IR[5] writes A, d2=IR[4] writes D, d3=IR[3] writes M.
  - writeM=d3 in EXEC only; outM=alu_o; addressM=old A.
  - EXEC edge: if d1, A<=alu_o. If d2, D<=alu_o.
  - Jump test: jump = (IR[2]&alu_ng) | (IR[1]&alu_zr) | (IR[0]&~alu_ng&~alu_zr).
  - PC update: pc <= jump ? old A[ADDR_W-1:0] : pc+1. Target is the pre-writeback A, even when d1 is set in the same instruction.
- Outside EXEC: alu_x=D, alu_y=A, outM=alu_o, addressM=A always.
- PC arithmetic is modulo 2^ADDR_W; pc+1 from all-ones wraps to 0.
- instr_valid while in EXEC is ignored; that instruction is not consumed.
- No other state exists; nothing is pipelined across instructions.

Test Plan:
- Reset then 0x000C (@12), 0xEC10 (D=A) -> D=12, A=12, pc=2, each instruction accepted with instr_ready high for one cycle.
- Then 0xE090 (D=D+A) -> ALU bits 000010, D=24. Then 0xE308 (M=D) -> writeM=1 for exactly one EXEC cycle, addressM=12, outM=24; D unchanged.
- 0x0064 (@100), 0xE304 (D;JLT, D=24) -> no jump, pc+1. Then 0xE301 (D;JGT) -> pc=100. Then 0xEA87 (0;JMP) -> alu_zr=1, pc=100.
- A=12, inM=0xBEEF, 0xFC10 (D=M, a=1) -> alu_y=0xBEEF, D=0xBEEF. Hold instr_valid low 5 cycles in FETCH -> no state change.
- RESET_PC=0x7FFF, 0x0005 -> pc=0x0000 (wrap), A=5. Assert rst_n=0 mid-EXEC of 0xE308 -> writeM drops immediately, A=D=0, pc=RESET_PC, instr_ready=1.
